// File: rtl/multiplier_control_if.sv
// Signal bundle between the add-shift multiplier control unit and its
// surroundings: raw push buttons and the multiplier LSB in, strobes out.
interface multiplier_control_if;
    logic Run_n;
    logic ClearA_LoadB_n;
    logic M;
    logic ClearA;
    logic LoadB;
    logic Add;
    logic Sub;
    logic Shift;
    logic Busy;
    logic Done;

    // Environment side: drives the buttons and the datapath LSB.
    modport master (
        output Run_n,
        output ClearA_LoadB_n,
        output M,
        input  ClearA,
        input  LoadB,
        input  Add,
        input  Sub,
        input  Shift,
        input  Busy,
        input  Done
    );

    // Control unit side.
    modport slave (
        input  Run_n,
        input  ClearA_LoadB_n,
        input  M,
        output ClearA,
        output LoadB,
        output Add,
        output Sub,
        output Shift,
        output Busy,
        output Done
    );
endinterface

// File: rtl/multiplier_control.sv
// Sequencer for the N_BITS x N_BITS add-shift multiplier datapath.
// Synchronizes the Run and ClearA_LoadB buttons, then walks the datapath
// through one clear and N_BITS add/subtract + arithmetic-shift iterations.
// The final iteration subtracts because the multiplier MSB carries
// negative weight in two's complement.
module multiplier_control #(
    parameter int N_BITS = 8
) (
    input logic                 Clk,
    input logic                 Reset,
    multiplier_control_if.slave bus
);

    localparam int CNT_W = $clog2(N_BITS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_BITS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLR   = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    logic run_p0;
    logic run_p1;
    logic clb_p0;
    logic clb_p1;
    logic run_s;
    logic clb_s;
    logic is_last;

    logic clear_a;
    logic load_b;
    logic add;
    logic sub;
    logic shift;
    logic busy;
    logic done;

    // Two-flop synchronizers; reset to 1 so the buttons read as released.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            run_p0 <= 1'b1;
            run_p1 <= 1'b1;
            clb_p0 <= 1'b1;
            clb_p1 <= 1'b1;
        end else begin
            run_p0 <= bus.Run_n;
            run_p1 <= run_p0;
            clb_p0 <= bus.ClearA_LoadB_n;
            clb_p1 <= clb_p0;
        end
    end

    assign run_s   = ~run_p1;
    assign clb_s   = ~clb_p1;
    assign is_last = (count == LAST);

    // State and iteration counter registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
        end
    end

    // Next-state and strobe decode; Add/Sub follow M combinationally.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        clear_a   = 1'b0;
        load_b    = 1'b0;
        add       = 1'b0;
        sub       = 1'b0;
        shift     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // Run wins over a simultaneous load request.
                if (run_s) begin
                    state_nxt = CLR;
                end else begin
                    clear_a = clb_s;
                    load_b  = clb_s;
                end
            end
            CLR: begin
                clear_a   = 1'b1;
                busy      = 1'b1;
                count_nxt = '0;
                state_nxt = ADD;
            end
            ADD: begin
                busy = 1'b1;
                if (bus.M) begin
                    sub = is_last;
                    add = ~is_last;
                end
                state_nxt = SHIFT;
            end
            SHIFT: begin
                busy      = 1'b1;
                shift     = 1'b1;
                count_nxt = count + CNT_W'(1);
                state_nxt = is_last ? HOLD : ADD;
            end
            HOLD: begin
                // Wait for Run release so a held button cannot restart.
                done = 1'b1;
                if (!run_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign bus.ClearA = clear_a;
    assign bus.LoadB  = load_b;
    assign bus.Add    = add;
    assign bus.Sub    = sub;
    assign bus.Shift  = shift;
    assign bus.Busy   = busy;
    assign bus.Done   = done;

endmodule

// File: tb/tb_multiplier_control.sv
// Scoreboard bench for multiplier_control: a small datapath stand-in holds
// register B and feeds its LSB back as M. Each stimulus task pushes the
// cycle-stamped output vectors it expects; the monitor pops and compares
// every cycle where any strobe is active or the output vector changes.
module tb_multiplier_control;

    typedef struct {
        int         cyc;
        logic [6:0] vec;   // {ClearA, LoadB, Add, Sub, Shift, Busy, Done}
    } ev_t;

    logic Clk;
    logic Reset;
    int   cyc;
    int   total;
    int   bad;
    bit   mon_on;
    ev_t  expq[$];

    logic [7:0] sw;
    logic [7:0] b_reg;
    logic [7:0] cur_b;
    logic [6:0] prev_vec;

    multiplier_control_if bus();

    multiplier_control #(.N_BITS(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Cycle counter: number of rising edges seen so far.
    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Datapath stand-in: load B from switches, shift B right on Shift.
    initial b_reg = 8'h00;
    always @(posedge Clk) begin
        if (bus.LoadB)
            b_reg <= sw;
        else if (bus.Shift)
            b_reg <= {1'b0, b_reg[7:1]};
    end
    assign bus.M = b_reg[0];

    function automatic logic [6:0] out_vec();
        return {bus.ClearA, bus.LoadB, bus.Add, bus.Sub, bus.Shift, bus.Busy, bus.Done};
    endfunction

    function automatic void push(input int c, input logic [6:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        expq.push_back(e);
    endfunction

    // Monitor: compare each observed output event with the scoreboard head.
    initial prev_vec = 7'b0;
    always @(negedge Clk) begin
        logic [6:0] v;
        ev_t        e;
        if (mon_on) begin
            v = out_vec();
            if ((v !== prev_vec) || (v[6:2] != 5'b0)) begin
                total = total + 1;
                if (expq.size() == 0) begin
                    bad = bad + 1;
                    $display("FAIL unexpected_event cyc=%0d got=%b expected=none", cyc, v);
                end else begin
                    e = expq.pop_front();
                    if ((e.cyc != cyc) || (e.vec !== v)) begin
                        bad = bad + 1;
                        $display("FAIL event cyc=%0d got=%b expected cyc=%0d vec=%b",
                                 cyc, v, e.cyc, e.vec);
                    end
                end
            end
            prev_vec = v;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    // Hold ClearA_LoadB for k cycles: k cycles of ClearA+LoadB, 2 cycles late.
    task automatic load(input logic [7:0] val, input int k);
        int p;
        sw = val;
        p  = cyc;
        bus.ClearA_LoadB_n = 1'b0;
        for (int j = 0; j < k; j++) push(p + 2 + j, 7'b1100000);
        push(p + k + 2, 7'b0000000);
        step(k);
        bus.ClearA_LoadB_n = 1'b1;
        step(4);
        cur_b = val;
    endtask

    // Expected CLR plus the first n_iter add/shift iterations after a press at p.
    task automatic push_iters(input int p, input int n_iter);
        logic a;
        logic s;
        push(p + 3, 7'b1000010);
        for (int i = 0; i < n_iter; i++) begin
            a = cur_b[i] && (i < 7);
            s = cur_b[i] && (i == 7);
            push(p + 4 + 2 * i, {2'b00, a, s, 3'b010});
            push(p + 5 + 2 * i, 7'b0000110);
        end
    endtask

    // Run press held for 'hold' cycles. mode 0: Run only; 1: load button
    // pressed while busy; 2: both buttons pressed together.
    task automatic run_seq(input int hold, input int mode);
        int p;
        p = cyc;
        bus.Run_n = 1'b0;
        if (mode == 2) bus.ClearA_LoadB_n = 1'b0;
        push_iters(p, 8);
        push(p + 20, 7'b0000001);
        push(p + hold + 3, 7'b0000000);
        if (mode == 1) begin
            step(5);
            bus.ClearA_LoadB_n = 1'b0;
            step(5);
            bus.ClearA_LoadB_n = 1'b1;
            step(hold - 10);
        end else begin
            step(hold);
        end
        bus.Run_n          = 1'b1;
        bus.ClearA_LoadB_n = 1'b1;
        step(6);
        cur_b = 8'h00;
    endtask

    // Reset pulse during the SHIFT cycle with count == 3.
    task automatic reset_mid();
        int p;
        p = cyc;
        bus.Run_n = 1'b0;
        push_iters(p, 4);
        push(p + 12, 7'b0000000);
        step(11);
        Reset     = 1'b0;
        bus.Run_n = 1'b1;
        step(1);
        Reset = 1'b1;
        step(4);
    endtask

    initial begin
        logic [6:0] v;
        total  = 0;
        bad    = 0;
        mon_on = 1'b0;
        sw     = 8'h00;
        cur_b  = 8'h00;
        Reset  = 1'b0;
        bus.Run_n          = 1'b1;
        bus.ClearA_LoadB_n = 1'b1;

        step(3);
        v = out_vec();
        total = total + 1;
        if (v !== 7'b0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs got=%b expected=%b", v, 7'b0);
        end
        Reset  = 1'b1;
        mon_on = 1'b1;
        step(2);

        load(8'hFF, 3);            // M effectively tied 1
        run_seq(25, 0);
        load(8'h00, 2);            // M effectively tied 0
        run_seq(22, 0);
        load(8'($urandom), 1);     // Run held 60 cycles
        run_seq(60, 0);
        load(8'($urandom), 5);     // load button during busy
        run_seq(30, 1);
        load(8'($urandom), 2);     // both buttons together
        run_seq(24, 2);
        load(8'($urandom), 2);
        reset_mid();
        load(8'hA5, 2);
        run_seq(18, 0);

        for (int it = 0; it < 8; it++) begin
            load(8'($urandom), int'($urandom_range(1, 5)));
            run_seq(int'($urandom_range(18, 40)), int'($urandom_range(0, 2)));
        end

        step(10);
        while (expq.size() != 0) begin
            ev_t e;
            e = expq.pop_front();
            total = total + 1;
            bad   = bad + 1;
            $display("FAIL missing_event got=none expected cyc=%0d vec=%b", e.cyc, e.vec);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
